// File: rtl/count_pkg.sv
// Shared types and constants for the count sequence checker family.
package count_pkg;

    localparam int unsigned DEFAULT_MAX_COUNT = 128;
    localparam int unsigned ERR_CNT_W         = 8;
    localparam int unsigned WRAP_CNT_W        = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

endpackage

// File: rtl/count_next_calc.sv
// Combinational predictor of the next wrap-counter value after cur.
module count_next_calc #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_COUNT = 128
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt_c
);

    assign nxt_c = (cur == WIDTH'(MAX_COUNT)) ? '0 : WIDTH'(cur + WIDTH'(1));

endmodule

// File: rtl/count_seq_checker.sv
// Passive wrap-counter output monitor: locks onto a valid sequence and flags deviations.
// Optional wrap statistics enabled by defining COUNT_SEQ_CHECKER_WRAP_STATS_EN.
module count_seq_checker
    import count_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MAX_COUNT   = DEFAULT_MAX_COUNT,
    parameter int unsigned LOCK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  smp_en,
    input  logic [WIDTH-1:0]      q,
    output logic                  locked,
    output logic                  err,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
);

    state_e                 state, state_nxt;
    logic [WIDTH-1:0]       prev, prev_nxt;
    logic [3:0]             match, match_nxt;
    logic                   err_nxt;
    logic [ERR_CNT_W-1:0]   err_cnt_nxt;
    logic [WIDTH-1:0]       exp_c;
    logic                   q_over_c;
    logic                   ok_c;

    count_next_calc #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_next_calc (
        .cur   (prev),
        .nxt_c (exp_c)
    );

    assign q_over_c = (q > WIDTH'(MAX_COUNT));
    assign ok_c     = (q == exp_c) && !q_over_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prev    <= '0;
            match   <= '0;
            locked  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_nxt;
            prev    <= prev_nxt;
            match   <= match_nxt;
            locked  <= (state_nxt == LOCKED);
            err     <= err_nxt;
            err_cnt <= err_cnt_nxt;
        end
    end

    // Every enabled sample updates prev; out-of-range samples force a restart from IDLE.
    always_comb begin
        state_nxt   = state;
        prev_nxt    = prev;
        match_nxt   = match;
        err_nxt     = 1'b0;
        err_cnt_nxt = err_cnt;
        if (smp_en) begin
            prev_nxt = q;
            unique case (state)
                IDLE: begin
                    match_nxt = '0;
                    if (!q_over_c) state_nxt = ACQUIRE;
                end
                ACQUIRE: begin
                    if (ok_c) begin
                        match_nxt = 4'(match + 4'd1);
                        if (4'(match + 4'd1) == 4'(LOCK_CYCLES)) state_nxt = LOCKED;
                    end else begin
                        match_nxt = '0;
                        if (q_over_c) state_nxt = IDLE;
                    end
                end
                LOCKED: begin
                    if (!ok_c) begin
                        err_nxt   = 1'b1;
                        match_nxt = '0;
                        state_nxt = q_over_c ? IDLE : ACQUIRE;
                        if (err_cnt != '1) err_cnt_nxt = ERR_CNT_W'(err_cnt + ERR_CNT_W'(1));
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef COUNT_SEQ_CHECKER_WRAP_STATS_EN
    logic wrap_hit_c;

    assign wrap_hit_c = smp_en && (state == LOCKED) && ok_c
                        && (prev == WIDTH'(MAX_COUNT)) && (q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_cnt <= '0;
        end else if (wrap_hit_c) begin
            wrap_cnt <= WRAP_CNT_W'(wrap_cnt + WRAP_CNT_W'(1));
        end
    end
`else
    assign wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed self-checking bench for count_seq_checker (default parameters).
module tb_count_seq_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        smp_en;
    logic [7:0]  q;
    logic        locked;
    logic        err;
    logic [7:0]  err_cnt;
    logic [15:0] wrap_cnt;

    int errors = 0;
    int checks = 0;

`ifdef COUNT_SEQ_CHECKER_WRAP_STATS_EN
    localparam int unsigned WRAP_ONE = 1;
`else
    localparam int unsigned WRAP_ONE = 0;
`endif

    always #5 clk = ~clk;

    count_seq_checker #(
        .WIDTH       (8),
        .MAX_COUNT   (128),
        .LOCK_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .smp_en   (smp_en),
        .q        (q),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt),
        .wrap_cnt (wrap_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Present one sample, let the edge consume it, then settle before checking.
    task automatic step(input logic en, input logic [7:0] val);
        smp_en = en;
        q      = val;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        smp_en = 1'b0;
        q      = '0;
        @(posedge clk);
        #1;
        step(1'b1, 8'd55);
        rst = 1'b0;
        check_eq("rst_locked", 32'(locked), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_err_cnt", 32'(err_cnt), 0);
        check_eq("rst_wrap_cnt", 32'(wrap_cnt), 0);

        // Initial acquisition: 0..3 not yet locked, 4 locks
        for (int v = 0; v < 4; v++) begin
            step(1'b1, 8'(v));
            check_eq("acq_not_locked", 32'(locked), 0);
        end
        step(1'b1, 8'd4);
        check_eq("acq_locked", 32'(locked), 1);
        check_eq("acq_err", 32'(err), 0);

        // Run up through MAX_COUNT and wrap
        for (int v = 5; v <= 128; v++) step(1'b1, 8'(v));
        check_eq("pre_wrap_cnt", 32'(wrap_cnt), 0);
        step(1'b1, 8'd0);
        check_eq("wrap_err", 32'(err), 0);
        check_eq("wrap_cnt_inc", 32'(wrap_cnt), WRAP_ONE);
        step(1'b1, 8'd1);
        check_eq("post_wrap_locked", 32'(locked), 1);
        check_eq("post_wrap_cnt", 32'(wrap_cnt), WRAP_ONE);
        check_eq("run_err_cnt", 32'(err_cnt), 0);

        // Skip a value while locked
        for (int v = 2; v <= 10; v++) step(1'b1, 8'(v));
        step(1'b1, 8'd12);
        check_eq("skip_err", 32'(err), 1);
        check_eq("skip_err_cnt", 32'(err_cnt), 1);
        check_eq("skip_unlocked", 32'(locked), 0);
        step(1'b1, 8'd13);
        check_eq("skip_err_pulse", 32'(err), 0);
        step(1'b1, 8'd14);
        step(1'b1, 8'd15);
        check_eq("relock_pending", 32'(locked), 0);
        step(1'b1, 8'd16);
        check_eq("relock", 32'(locked), 1);

        // Out-of-range value while locked
        for (int v = 17; v <= 20; v++) step(1'b1, 8'(v));
        step(1'b1, 8'd200);
        check_eq("over_err", 32'(err), 1);
        check_eq("over_err_cnt", 32'(err_cnt), 2);
        check_eq("over_unlocked", 32'(locked), 0);
        for (int v = 5; v <= 8; v++) step(1'b1, 8'(v));
        check_eq("over_relock_pending", 32'(locked), 0);
        step(1'b1, 8'd9);
        check_eq("over_relock", 32'(locked), 1);
        check_eq("over_relock_err", 32'(err), 0);

        // Sampling gap with garbage on q
        for (int v = 10; v <= 20; v++) step(1'b1, 8'(v));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'(100 + i * 37));
            check_eq("gap_locked", 32'(locked), 1);
            check_eq("gap_err", 32'(err), 0);
        end
        step(1'b1, 8'd21);
        check_eq("gap_resume_err", 32'(err), 0);
        check_eq("gap_resume_locked", 32'(locked), 1);
        check_eq("gap_err_cnt", 32'(err_cnt), 2);

        // Repeated value is a violation
        step(1'b1, 8'd21);
        check_eq("repeat_err", 32'(err), 1);
        check_eq("repeat_err_cnt", 32'(err_cnt), 3);

        // Relock (no error raised while acquiring)
        for (int v = 30; v <= 34; v++) step(1'b1, 8'(v));
        check_eq("prep_locked", 32'(locked), 1);
        check_eq("prep_err_cnt", 32'(err_cnt), 3);

        // 300 forced errors: each 30 after 34 violates, then 31..34 relocks
        for (int k = 1; k <= 300; k++) begin
            step(1'b1, 8'd30);
            if (k == 251) check_eq("sat_254", 32'(err_cnt), 254);
            if (k == 252) check_eq("sat_255", 32'(err_cnt), 255);
            if (k == 300) check_eq("sat_err_pulse", 32'(err), 1);
            for (int v = 31; v <= 34; v++) step(1'b1, 8'(v));
        end
        check_eq("sat_hold", 32'(err_cnt), 255);
        check_eq("sat_locked", 32'(locked), 1);

        // Reset dominates a valid sample while locked
        rst = 1'b1;
        step(1'b1, 8'd35);
        check_eq("mid_rst_locked", 32'(locked), 0);
        check_eq("mid_rst_err", 32'(err), 0);
        check_eq("mid_rst_err_cnt", 32'(err_cnt), 0);
        check_eq("mid_rst_wrap_cnt", 32'(wrap_cnt), 0);
        rst = 1'b0;
        step(1'b1, 8'd36);
        check_eq("post_rst_locked", 32'(locked), 0);
        check_eq("post_rst_err", 32'(err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
